// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter
// Shares one single-port SRAM macro between the instruction-fetch port and
// the load/store data port. At most one access is granted per cycle. The
// granted request drives the SRAM in the same cycle. The read data (or a
// write ack) is routed back to the issuing port one cycle later.
//
// Configuration macro: SRAM_ARB_RR_EN
//   defined   - round-robin arbitration using a 1-bit last-grant pointer
//   undefined - data-over-fetch fixed priority. A pending fetch wins after
//               losing MAX_WAIT consecutive cycles.
//
// Ports
//   clk_i, rst_i              clock, synchronous active-high reset
//   if_valid_i/if_addr_i      fetch request (read-only)
//   if_ready_o                fetch request accepted this cycle
//   if_rsp_valid_o/if_rdata_o fetch response, one cycle after accept
//   d_valid_i/d_we_i/d_addr_i/d_wdata_i/d_wmask_i   data request
//   d_ready_o                 data request accepted this cycle
//   d_rsp_valid_o/d_rdata_o   data response (read data or write ack)
//   sram_*                    SRAM macro interface (csb/web active-low)
module sram_port_arbiter #(
    parameter int unsigned ADDR_W   = 13,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              if_valid_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_ready_o,
    output logic              if_rsp_valid_o,
    output logic [DATA_W-1:0] if_rdata_o,
    input  logic              d_valid_i,
    input  logic              d_we_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic [DATA_W-1:0] d_wdata_i,
    input  logic [3:0]        d_wmask_i,
    output logic              d_ready_o,
    output logic              d_rsp_valid_o,
    output logic [DATA_W-1:0] d_rdata_o,
    output logic              sram_csb_o,
    output logic              sram_web_o,
    output logic [ADDR_W-1:0] sram_addr_o,
    output logic [DATA_W-1:0] sram_wdata_o,
    output logic [3:0]        sram_wmask_o,
    input  logic [DATA_W-1:0] sram_rdata_i
);

    localparam int unsigned MASK_W = 4;

    logic grant_if_c;
    logic grant_d_c;
    logic fetch_first_c;   // fetch beats data when both are valid
    logic rsp_pend_q;
    logic rsp_port_q;      // 1 = data port owns the pending response

`ifdef SRAM_ARB_RR_EN
    // Last-grant pointer: 1 = data was granted last. Reset to fetch-last.
    logic last_d_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_d_q <= 1'b0;
        end else if (grant_if_c || grant_d_c) begin
            last_d_q <= grant_d_c;
        end
    end

    assign fetch_first_c = last_d_q;
`else
    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(MAX_WAIT);

    // Consecutive cycles a pending fetch has lost; saturates at the limit.
    logic [CNT_W-1:0] wait_cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wait_cnt_q <= '0;
        end else if (!if_valid_i || grant_if_c) begin
            wait_cnt_q <= '0;
        end else if (wait_cnt_q != WAIT_LIMIT) begin
            wait_cnt_q <= wait_cnt_q + CNT_W'(1);
        end
    end

    assign fetch_first_c = (wait_cnt_q == WAIT_LIMIT);
`endif

    // Grant decode; nothing is granted while reset is held.
    assign grant_if_c = !rst_i && if_valid_i && (!d_valid_i || fetch_first_c);
    assign grant_d_c  = !rst_i && d_valid_i && !grant_if_c;

    assign if_ready_o = grant_if_c;
    assign d_ready_o  = grant_d_c;

    // Winner drives the SRAM in the grant cycle; idle bus is parked at zero.
    always_comb begin
        sram_csb_o   = 1'b1;
        sram_web_o   = 1'b1;
        sram_addr_o  = '0;
        sram_wdata_o = '0;
        sram_wmask_o = '0;
        if (grant_d_c) begin
            sram_csb_o   = 1'b0;
            sram_web_o   = !d_we_i;
            sram_addr_o  = d_addr_i;
            sram_wdata_o = d_wdata_i;
            sram_wmask_o = d_wmask_i;
        end else if (grant_if_c) begin
            sram_csb_o   = 1'b0;
            sram_addr_o  = if_addr_i;
            sram_wmask_o = MASK_W'(0);
        end
    end

    // Response tag: remembers which port owns next cycle's SRAM output.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rsp_pend_q <= 1'b0;
            rsp_port_q <= 1'b0;
        end else begin
            rsp_pend_q <= grant_if_c || grant_d_c;
            rsp_port_q <= grant_d_c;
        end
    end

    assign if_rsp_valid_o = !rst_i && rsp_pend_q && !rsp_port_q;
    assign d_rsp_valid_o  = !rst_i && rsp_pend_q && rsp_port_q;
    assign if_rdata_o     = sram_rdata_i;
    assign d_rdata_o      = sram_rdata_i;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: directed scenarios from the block's test plan
// plus a randomized run against a reference model of the arbitration rules.
module tb_sram_port_arbiter;

    localparam int unsigned ADDR_W   = 13;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned MAX_WAIT = 4;
    localparam int unsigned DEPTH    = 8192;

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b1;
    logic              if_valid_i = 1'b0;
    logic [ADDR_W-1:0] if_addr_i = '0;
    logic              if_ready_o;
    logic              if_rsp_valid_o;
    logic [DATA_W-1:0] if_rdata_o;
    logic              d_valid_i = 1'b0;
    logic              d_we_i = 1'b0;
    logic [ADDR_W-1:0] d_addr_i = '0;
    logic [DATA_W-1:0] d_wdata_i = '0;
    logic [3:0]        d_wmask_i = '0;
    logic              d_ready_o;
    logic              d_rsp_valid_o;
    logic [DATA_W-1:0] d_rdata_o;
    logic              sram_csb_o;
    logic              sram_web_o;
    logic [ADDR_W-1:0] sram_addr_o;
    logic [DATA_W-1:0] sram_wdata_o;
    logic [3:0]        sram_wmask_o;
    logic [DATA_W-1:0] sram_rdata_i = '0;

    int n_checks = 0;
    int n_errors = 0;

    logic [DATA_W-1:0] sram_mem [DEPTH];
    logic [DATA_W-1:0] ref_mem  [DEPTH];

    always #5 clk_i = ~clk_i;

    sram_port_arbiter #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .MAX_WAIT(MAX_WAIT)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .if_valid_i    (if_valid_i),
        .if_addr_i     (if_addr_i),
        .if_ready_o    (if_ready_o),
        .if_rsp_valid_o(if_rsp_valid_o),
        .if_rdata_o    (if_rdata_o),
        .d_valid_i     (d_valid_i),
        .d_we_i        (d_we_i),
        .d_addr_i      (d_addr_i),
        .d_wdata_i     (d_wdata_i),
        .d_wmask_i     (d_wmask_i),
        .d_ready_o     (d_ready_o),
        .d_rsp_valid_o (d_rsp_valid_o),
        .d_rdata_o     (d_rdata_o),
        .sram_csb_o    (sram_csb_o),
        .sram_web_o    (sram_web_o),
        .sram_addr_o   (sram_addr_o),
        .sram_wdata_o  (sram_wdata_o),
        .sram_wmask_o  (sram_wmask_o),
        .sram_rdata_i  (sram_rdata_i)
    );

    // Behavioural single-port SRAM macro: byte-masked write, registered read.
    always @(posedge clk_i) begin
        if (!sram_csb_o) begin
            sram_rdata_i <= sram_mem[sram_addr_o];
            if (!sram_web_o) begin
                for (int b = 0; b < 4; b++) begin
                    if (sram_wmask_o[b]) sram_mem[sram_addr_o][8*b +: 8] = sram_wdata_o[8*b +: 8];
                end
            end
        end
    end

    function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old_w,
                                                input logic [DATA_W-1:0] new_w,
                                                input logic [3:0] mask);
        logic [DATA_W-1:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++) if (mask[b]) r[8*b +: 8] = new_w[8*b +: 8];
        return r;
    endfunction

    function automatic logic [ADDR_W-1:0] rand_addr();
        int unsigned a;
        a = $urandom_range(0, 15);
        return (a < 8) ? ADDR_W'(a) : ADDR_W'(13'h1FF0 | a);
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_i      = 1'b1;
        if_valid_i = 1'b0;
        d_valid_i  = 1'b0;
        tick();
        rst_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        for (int c = 0; c < 3; c++) begin
            if_valid_i = 1'b1;
            if_addr_i  = rand_addr();
            d_valid_i  = 1'b1;
            d_we_i     = 1'($urandom_range(0, 1));
            d_addr_i   = rand_addr();
            @(negedge clk_i);
            n_checks++;
            if ({if_ready_o, d_ready_o, sram_csb_o, sram_web_o, if_rsp_valid_o, d_rsp_valid_o} !== 6'b001100) begin
                n_errors++;
                $display("FAIL reset_outputs cyc %0d: got %b expected 001100", c,
                         {if_ready_o, d_ready_o, sram_csb_o, sram_web_o, if_rsp_valid_o, d_rsp_valid_o});
            end
            tick();
        end
        if_valid_i = 1'b0;
        d_valid_i  = 1'b0;
        rst_i      = 1'b0;
    endtask

    task automatic test_fetch_read();
        do_reset();
        sram_mem[13'h0010] = 32'hDEADBEEF;
        if_valid_i = 1'b1;
        if_addr_i  = 13'h0010;
        @(negedge clk_i);
        n_checks++;
        if ({if_ready_o, d_ready_o, sram_csb_o, sram_web_o, sram_addr_o, sram_wmask_o} !==
            {1'b1, 1'b0, 1'b0, 1'b1, 13'h0010, 4'h0}) begin
            n_errors++;
            $display("FAIL fetch_grant: got rdy=%b%b csb=%b web=%b addr=%h mask=%h expected 10 0 1 0010 0",
                     if_ready_o, d_ready_o, sram_csb_o, sram_web_o, sram_addr_o, sram_wmask_o);
        end
        tick();
        if_valid_i = 1'b0;
        @(negedge clk_i);
        n_checks++;
        if ({if_rsp_valid_o, d_rsp_valid_o, if_rdata_o} !== {2'b10, 32'hDEADBEEF}) begin
            n_errors++;
            $display("FAIL fetch_rsp: got v=%b%b data=%h expected 10 deadbeef",
                     if_rsp_valid_o, d_rsp_valid_o, if_rdata_o);
        end
        tick();
    endtask

    task automatic test_data_write();
        do_reset();
        sram_mem[13'h1FFF] = 32'hAABBCCDD;
        d_valid_i = 1'b1;
        d_we_i    = 1'b1;
        d_addr_i  = 13'h1FFF;
        d_wdata_i = 32'h12345678;
        d_wmask_i = 4'h3;
        @(negedge clk_i);
        n_checks++;
        if ({d_ready_o, if_ready_o, sram_csb_o, sram_web_o, sram_addr_o, sram_wdata_o, sram_wmask_o} !==
            {4'b1000, 13'h1FFF, 32'h12345678, 4'h3}) begin
            n_errors++;
            $display("FAIL write_grant: got rdy=%b%b csb=%b web=%b addr=%h wd=%h mask=%h expected 10 0 0 1fff 12345678 3",
                     d_ready_o, if_ready_o, sram_csb_o, sram_web_o, sram_addr_o, sram_wdata_o, sram_wmask_o);
        end
        tick();
        d_valid_i  = 1'b0;
        if_valid_i = 1'b1;
        if_addr_i  = 13'h1FFF;
        @(negedge clk_i);
        n_checks++;
        if ({d_rsp_valid_o, if_rsp_valid_o, if_ready_o} !== 3'b101) begin
            n_errors++;
            $display("FAIL write_ack: got drsp=%b ifrsp=%b ifrdy=%b expected 1 0 1",
                     d_rsp_valid_o, if_rsp_valid_o, if_ready_o);
        end
        tick();
        if_valid_i = 1'b0;
        @(negedge clk_i);
        n_checks++;
        if ({if_rsp_valid_o, d_rsp_valid_o, if_rdata_o} !== {2'b10, 32'hAABB5678}) begin
            n_errors++;
            $display("FAIL write_readback: got v=%b%b data=%h expected 10 aabb5678",
                     if_rsp_valid_o, d_rsp_valid_o, if_rdata_o);
        end
        tick();
    endtask

    // Both ports valid every cycle: check the grant pattern and response routing.
    task automatic test_back_to_back();
        logic exp_f;
        logic prev_f;
        do_reset();
        sram_mem[13'h0020] = 32'h0F0F_1111;
        sram_mem[13'h0021] = 32'hD0D0_2222;
        if_valid_i = 1'b1;
        if_addr_i  = 13'h0020;
        d_valid_i  = 1'b1;
        d_we_i     = 1'b0;
        d_addr_i   = 13'h0021;
        prev_f     = 1'b0;
        for (int i = 0; i < 12; i++) begin
`ifdef SRAM_ARB_RR_EN
            exp_f = (i % 2) == 1;
`else
            exp_f = ((i + 1) % (MAX_WAIT + 1)) == 0;
`endif
            @(negedge clk_i);
            n_checks++;
            if ({if_ready_o, d_ready_o} !== {exp_f, !exp_f}) begin
                n_errors++;
                $display("FAIL b2b_grant cyc %0d: got if/d ready %b%b expected %b%b",
                         i, if_ready_o, d_ready_o, exp_f, !exp_f);
            end
            if (i > 0) begin
                n_checks++;
                if ({if_rsp_valid_o, d_rsp_valid_o, (prev_f ? if_rdata_o : d_rdata_o)} !==
                    {prev_f, !prev_f, (prev_f ? 32'h0F0F_1111 : 32'hD0D0_2222)}) begin
                    n_errors++;
                    $display("FAIL b2b_rsp cyc %0d: got v=%b%b data=%h expected fetch_port=%b",
                             i, if_rsp_valid_o, d_rsp_valid_o, (prev_f ? if_rdata_o : d_rdata_o), prev_f);
                end
            end
            prev_f = exp_f;
            tick();
        end
        if_valid_i = 1'b0;
        d_valid_i  = 1'b0;
        tick();
    endtask

    task automatic test_reset_midflight();
        do_reset();
        d_valid_i = 1'b1;
        d_we_i    = 1'b0;
        d_addr_i  = 13'h0005;
        @(negedge clk_i);
        n_checks++;
        if (d_ready_o !== 1'b1) begin
            n_errors++;
            $display("FAIL midrst_accept: got d_ready=%b expected 1", d_ready_o);
        end
        tick();
        rst_i      = 1'b1;
        if_valid_i = 1'b1;
        @(negedge clk_i);
        n_checks++;
        if ({if_ready_o, d_ready_o, sram_csb_o, sram_web_o, if_rsp_valid_o, d_rsp_valid_o} !== 6'b001100) begin
            n_errors++;
            $display("FAIL midrst_during: got %b expected 001100",
                     {if_ready_o, d_ready_o, sram_csb_o, sram_web_o, if_rsp_valid_o, d_rsp_valid_o});
        end
        tick();
        rst_i      = 1'b0;
        if_valid_i = 1'b0;
        d_valid_i  = 1'b0;
        @(negedge clk_i);
        n_checks++;
        if ({if_rsp_valid_o, d_rsp_valid_o} !== 2'b00) begin
            n_errors++;
            $display("FAIL midrst_after: got rsp %b%b expected 00", if_rsp_valid_o, d_rsp_valid_o);
        end
        tick();
    endtask

    task automatic test_idle();
        for (int c = 0; c < 10; c++) begin
            @(negedge clk_i);
            n_checks++;
            if ({if_ready_o, d_ready_o, sram_csb_o, sram_web_o, if_rsp_valid_o, d_rsp_valid_o,
                 sram_addr_o, sram_wdata_o, sram_wmask_o} !== {6'b001100, 13'h0, 32'h0, 4'h0}) begin
                n_errors++;
                $display("FAIL idle cyc %0d: got ctl=%b addr=%h wd=%h mask=%h expected 001100 0 0 0", c,
                         {if_ready_o, d_ready_o, sram_csb_o, sram_web_o, if_rsp_valid_o, d_rsp_valid_o},
                         sram_addr_o, sram_wdata_o, sram_wmask_o);
            end
            tick();
        end
    endtask

    // Random traffic against a model of the arbitration rules and memory contents.
    task automatic test_random();
        int unsigned       m_lost;     // consecutive cycles a pending fetch has lost
        logic              m_last_d;   // data port won the most recent grant
        logic              fetch_first, gf, gd;
        logic              p_if, p_d, p_rd;
        logic [DATA_W-1:0] p_data, got_data;
        logic              e_csb, e_web;
        logic [ADDR_W-1:0] e_addr;
        logic [DATA_W-1:0] e_wdata;
        logic [3:0]        e_mask;
        do_reset();
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = sram_mem[i];
        m_lost = 0; m_last_d = 1'b0; p_if = 1'b0; p_d = 1'b0; p_rd = 1'b0; p_data = '0;
        for (int c = 0; c < 600; c++) begin
            if (!if_valid_i && $urandom_range(0, 3) != 0) begin
                if_valid_i = 1'b1;
                if_addr_i  = rand_addr();
            end
            if (!d_valid_i && $urandom_range(0, 3) != 0) begin
                d_valid_i = 1'b1;
                d_we_i    = 1'($urandom_range(0, 1));
                d_addr_i  = rand_addr();
                d_wdata_i = $urandom;
                d_wmask_i = 4'($urandom_range(0, 15));
            end
            @(negedge clk_i);
`ifdef SRAM_ARB_RR_EN
            fetch_first = m_last_d;
`else
            fetch_first = (m_lost >= MAX_WAIT);
`endif
            gf = if_valid_i && (!d_valid_i || fetch_first);
            gd = d_valid_i && !gf;
            n_checks++;
            if ({if_ready_o, d_ready_o} !== {gf, gd}) begin
                n_errors++;
                $display("FAIL rnd_ready cyc %0d: got %b%b expected %b%b", c, if_ready_o, d_ready_o, gf, gd);
            end
            e_csb   = !(gf || gd);
            e_web   = !(gd && d_we_i);
            e_addr  = gf ? if_addr_i : (gd ? d_addr_i : '0);
            e_wdata = gd ? d_wdata_i : '0;
            e_mask  = gd ? d_wmask_i : '0;
            n_checks++;
            if ({sram_csb_o, sram_web_o, sram_addr_o, sram_wdata_o, sram_wmask_o} !==
                {e_csb, e_web, e_addr, e_wdata, e_mask}) begin
                n_errors++;
                $display("FAIL rnd_sram cyc %0d: got csb=%b web=%b addr=%h wd=%h mask=%h expected %b %b %h %h %h",
                         c, sram_csb_o, sram_web_o, sram_addr_o, sram_wdata_o, sram_wmask_o,
                         e_csb, e_web, e_addr, e_wdata, e_mask);
            end
            n_checks++;
            if ({if_rsp_valid_o, d_rsp_valid_o} !== {p_if, p_d}) begin
                n_errors++;
                $display("FAIL rnd_rsp_valid cyc %0d: got %b%b expected %b%b",
                         c, if_rsp_valid_o, d_rsp_valid_o, p_if, p_d);
            end
            if (p_if || (p_d && p_rd)) begin
                got_data = p_if ? if_rdata_o : d_rdata_o;
                n_checks++;
                if (got_data !== p_data) begin
                    n_errors++;
                    $display("FAIL rnd_rdata cyc %0d: got %h expected %h", c, got_data, p_data);
                end
            end
            tick();
            // Model update for the transfer that happened at this edge.
            p_if   = gf;
            p_d    = gd;
            p_rd   = gd && !d_we_i;
            p_data = gf ? ref_mem[if_addr_i] : ref_mem[d_addr_i];
            if (gd && d_we_i) ref_mem[d_addr_i] = merge(ref_mem[d_addr_i], d_wdata_i, d_wmask_i);
            if (if_valid_i && !gf) m_lost = m_lost + 1;
            else                   m_lost = 0;
            if (gf || gd) m_last_d = gd;
            if (gf) if_valid_i = 1'b0;
            if (gd) d_valid_i = 1'b0;
        end
        if_valid_i = 1'b0;
        d_valid_i  = 1'b0;
        tick();
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) sram_mem[i] = $urandom;
        test_reset();
        test_fetch_read();
        test_data_write();
        test_back_to_back();
        test_reset_midflight();
        test_idle();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
